// File: rtl/datapath_executor_pkg.sv
// ============================================================================
// Module : datapath_executor_pkg
// Brief  : Shared widths, instruction field offsets, opcodes and FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package datapath_executor_pkg;

  localparam int INSTRUCTION_WIDTH = 36;
  localparam int RESULT_WIDTH      = 32;
  localparam int OP_WIDTH          = 4;
  localparam int OP_LSB            = 0;
  localparam int OPA_LSB           = OP_LSB + OP_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_LOAD  = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_MAC   = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_READ  = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_RELU  = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_CLEAR = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_ACC  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/datapath_executor_seq_multiplier.sv
// ============================================================================
// Module : seq_multiplier
// Brief  : Radix-2 signed shift-add multiplier, one multiplier bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic                    done_o,
  output logic [2*DATA_WIDTH-1:0] product_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  logic [PW-1:0]         mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [PW-1:0]         prod_q;
  logic [PW-1:0]         prod_d;
  logic [CW-1:0]         cnt_q;
  logic                  run_q;
  logic                  last_step;
  logic [PW-1:0]         addend;

  assign last_step = (cnt_q == CW'(DATA_WIDTH - 1));
  assign addend    = mplier_q[0] ? mcand_q : '0;
  // The multiplier MSB carries weight -2^(W-1), so the final partial product is subtracted.
  assign prod_d    = last_step ? (prod_q - addend) : (prod_q + addend);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= PW'($signed(a_i));
      mplier_q <= b_i;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last_step) begin
        run_q <= 1'b0;
      end
    end
  end

  // done_o marks the cycle whose closing edge writes the final product.
  assign done_o    = run_q && last_step;
  assign product_o = prod_q;

endmodule

`default_nettype wire

// File: rtl/datapath_executor.sv
// ============================================================================
// Module : datapath_executor
// Brief  : Single-datapath instruction responder driving a fixed-point neuron accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module datapath_executor
  import datapath_executor_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
  input  logic                         start_dp,
  output logic [RESULT_WIDTH-1:0]      result_dp,
  output logic                         finished_dp,
  output logic                         busy,
  output logic                         error
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 2;

  localparam logic signed [PW-1:0] SH_MAX  = PW'(64'd1 << DATA_WIDTH);
  localparam logic signed [PW-1:0] SH_MIN  = -SH_MAX;
  localparam logic signed [SW-1:0] SUM_MAX = SW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [SW-1:0] SUM_MIN = ~SUM_MAX;

  state_e                       state_q, state_d;
  logic                         start_q;
  logic [OP_WIDTH-1:0]          op_q;
  logic [DATA_WIDTH-1:0]        a_q, b_q;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        result_q, result_d;
  logic                         fin_q, fin_d;
  logic                         err_q, err_d;
  logic                         mul_load;
  logic                         mul_done;
  logic signed [PW-1:0]         mul_product;
  logic                         accept;

  logic signed [PW-1:0]         shifted;
  logic signed [SW-1:0]         clamped;
  logic signed [SW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] sat;

  seq_multiplier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clock    (clock),
    .resetn   (resetn),
    .load_i   (mul_load),
    .a_i      (a_q),
    .b_i      (b_q),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  assign accept = (state_q == S_IDLE) && start_dp && !start_q;

  // Pre-clamping the shifted product to +/-2^W keeps the narrow sum exact without changing the saturated outcome.
  assign shifted = mul_product >>> FRAC_BITS;
  always_comb begin
    if (shifted > SH_MAX) begin
      clamped = SH_MAX[SW-1:0];
    end else if (shifted < SH_MIN) begin
      clamped = SH_MIN[SW-1:0];
    end else begin
      clamped = shifted[SW-1:0];
    end
  end
  assign sum = SW'(acc_q) + clamped;
  always_comb begin
    if (sum > SUM_MAX) begin
      sat = SUM_MAX[DATA_WIDTH-1:0];
    end else if (sum < SUM_MIN) begin
      sat = SUM_MIN[DATA_WIDTH-1:0];
    end else begin
      sat = sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      fin_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_dp;
      acc_q    <= acc_d;
      result_q <= result_d;
      fin_q    <= fin_d;
      err_q    <= err_d;
      if (accept) begin
        op_q <= instruction_dp[OP_LSB +: OP_WIDTH];
        a_q  <= instruction_dp[OPA_LSB +: DATA_WIDTH];
        b_q  <= instruction_dp[OPA_LSB + DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_MAC) ? S_MUL : S_IDLE;
      S_MUL:   if (mul_done) state_d = S_ACC;
      S_ACC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    fin_d    = fin_q;
    err_d    = err_q;
    mul_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) fin_d = 1'b0;
      end
      S_EXEC: begin
        fin_d = 1'b1;
        case (op_q)
          OP_NOP:   result_d = '0;
          OP_LOAD: begin
            acc_d    = a_q;
            result_d = a_q;
          end
          OP_MAC: begin
            mul_load = 1'b1;
            fin_d    = 1'b0;
          end
          OP_READ:  result_d = acc_q;
          OP_RELU:  result_d = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
          OP_CLEAR: begin
            acc_d    = '0;
            result_d = '0;
          end
          default: begin
            result_d = '1;
            err_d    = 1'b1;
          end
        endcase
      end
      S_MUL: ;
      S_ACC: begin
        acc_d    = sat;
        result_d = sat;
        fin_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign result_dp   = RESULT_WIDTH'($signed(result_q));
  assign finished_dp = fin_q;
  assign busy        = (state_q != S_IDLE);
  assign error       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_executor.sv
// ============================================================================
// Module : tb_datapath_executor
// Brief  : Directed-vector scoreboard bench for datapath_executor (DATA_WIDTH=16, FRAC_BITS=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_datapath_executor;
  import datapath_executor_pkg::*;

  logic                         clock;
  logic                         resetn;
  logic [INSTRUCTION_WIDTH-1:0] instruction_dp;
  logic                         start_dp;
  logic [RESULT_WIDTH-1:0]      result_dp;
  logic                         finished_dp;
  logic                         busy;
  logic                         error;

  int vecs = 0;
  int errs = 0;
  logic [RESULT_WIDTH:0] sb_q[$];
  logic mon_en  = 1'b0;
  logic prev_fin = 1'b1;
  logic exp_err = 1'b0;

  datapath_executor #(
    .DATA_WIDTH(16),
    .FRAC_BITS (8)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .instruction_dp(instruction_dp),
    .start_dp      (start_dp),
    .result_dp     (result_dp),
    .finished_dp   (finished_dp),
    .busy          (busy),
    .error         (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every rising edge of finished_dp is a completed instruction and consumes one expectation.
  always @(negedge clock) begin
    if (mon_en && finished_dp && !prev_fin) begin
      vecs++;
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_result: got result=%08h error=%0b, none expected", result_dp, error);
      end else begin
        logic [RESULT_WIDTH:0] exp;
        exp = sb_q.pop_front();
        if ({error, result_dp} !== exp) begin
          errs++;
          $display("FAIL result: got result=%08h error=%0b, expected result=%08h error=%0b",
                   result_dp, error, exp[RESULT_WIDTH-1:0], exp[RESULT_WIDTH]);
        end
      end
    end
    prev_fin = finished_dp;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input logic [31:0] exp_res, input int exp_low);
    int n;
    int low;
    logic done;
    @(negedge clock);
    instruction_dp = {b, a, op};
    start_dp = 1'b1;
    if (op > 4'd5) exp_err = 1'b1;
    sb_q.push_back({exp_err, exp_res});
    n = 0;
    low = 0;
    done = 1'b0;
    while (!(done && n >= hold) && n < 100) begin
      @(negedge clock);
      n++;
      if (n == hold) start_dp = 1'b0;
      if (!finished_dp) low++;
      else if (low > 0) done = 1'b1;
    end
    if (!done) begin
      vecs++;
      errs++;
      $display("FAIL timeout: op %0d never finished, got low=%0d, expected low=%0d", op, low, exp_low);
    end else begin
      check("finished_low_cycles", low, exp_low);
    end
    start_dp = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    start_dp = 1'b0;
    instruction_dp = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("reset_finished", {31'd0, finished_dp}, 32'd1);
    check("reset_result", result_dp, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    mon_en = 1'b1;

    issue(OP_LOAD,  16'h0180, 16'h0000, 1, 32'h0000_0180, 1);
    issue(OP_MAC,   16'h0180, 16'h0200, 1, 32'h0000_0480, 18);
    issue(OP_CLEAR, 16'h0000, 16'h0000, 1, 32'h0000_0000, 1);
    issue(OP_LOAD,  16'h7F00, 16'h0000, 1, 32'h0000_7F00, 1);
    issue(OP_MAC,   16'h7F00, 16'h7F00, 1, 32'h0000_7FFF, 18);
    issue(OP_LOAD,  16'hFF00, 16'h0000, 1, 32'hFFFF_FF00, 1);
    issue(OP_RELU,  16'h0000, 16'h0000, 1, 32'h0000_0000, 1);
    issue(OP_READ,  16'h0000, 16'h0000, 1, 32'hFFFF_FF00, 1);
    issue(OP_LOAD,  16'h0100, 16'h0000, 1, 32'h0000_0100, 1);
    issue(OP_RELU,  16'h0000, 16'h0000, 1, 32'h0000_0100, 1);
    // -1 LSB times 1 LSB shifts to -1, not 0.
    issue(OP_CLEAR, 16'h0000, 16'h0000, 1, 32'h0000_0000, 1);
    issue(OP_MAC,   16'hFFFF, 16'h0001, 1, 32'hFFFF_FFFF, 18);
    issue(OP_CLEAR, 16'h0000, 16'h0000, 1, 32'h0000_0000, 1);
    issue(OP_MAC,   16'hFF00, 16'h0180, 1, 32'hFFFF_FE80, 18);
    issue(OP_READ,  16'h0000, 16'h0000, 2, 32'hFFFF_FE80, 1);
    issue(OP_READ,  16'h0000, 16'h0000, 3, 32'hFFFF_FE80, 1);
    issue(OP_LOAD,  16'h8000, 16'h0000, 1, 32'hFFFF_8000, 1);
    issue(OP_MAC,   16'h7F00, 16'h8000, 1, 32'hFFFF_8000, 18);
    issue(OP_CLEAR, 16'h0000, 16'h0000, 1, 32'h0000_0000, 1);
    issue(OP_MAC,   16'h8000, 16'h8000, 1, 32'h0000_7FFF, 18);
    issue(4'd9,     16'h1234, 16'h5678, 1, 32'hFFFF_FFFF, 1);
    issue(OP_NOP,   16'h0000, 16'h0000, 1, 32'h0000_0000, 1);
    issue(OP_LOAD,  16'h0123, 16'h0000, 1, 32'h0000_0123, 1);

    // Abort a MAC during its seventh multiply cycle; no result may appear.
    @(negedge clock);
    instruction_dp = {16'h0100, 16'h0100, OP_MAC};
    start_dp = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (n == 1) start_dp = 1'b0;
      if (n == 4) check("mid_mac_busy", {31'd0, busy}, 32'd1);
    end
    mon_en = 1'b0;
    resetn = 1'b0;
    @(negedge clock);
    check("abort_finished", {31'd0, finished_dp}, 32'd1);
    check("abort_result", result_dp, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    resetn = 1'b1;
    exp_err = 1'b0;
    @(negedge clock);
    mon_en = 1'b1;
    issue(OP_READ,  16'h0000, 16'h0000, 1, 32'h0000_0000, 1);

    repeat (5) @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
